// File: rtl/riscv_pkg.sv
// Shared types for the RV64I pipeline control slice: in-flight table entry,
// control FSM states and forwarding-select encoding.
package riscv_pkg;

    // Widest register address an entry can hold; narrower addresses are zero-extended.
    localparam int RF_ADDR_MAX = 8;
    localparam int FWD_RF      = 0;

    typedef struct packed {
        logic                   valid;
        logic [RF_ADDR_MAX-1:0] rd;
        logic                   wr;
        logic                   ld;
    } pipe_entry_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } ctrl_state_e;

    localparam pipe_entry_t ENTRY_NONE = pipe_entry_t'({$bits(pipe_entry_t){1'b0}});

    // A write to x0 is architecturally invisible, so it never forwards.
    function automatic pipe_entry_t make_entry(input logic [RF_ADDR_MAX-1:0] rd,
                                               input logic wr, input logic ld);
        pipe_entry_t e;
        e.valid = 1'b1;
        e.rd    = rd;
        e.wr    = wr & (rd != {RF_ADDR_MAX{1'b0}});
        e.ld    = ld;
        return e;
    endfunction

endpackage

// File: rtl/riscv_pipe_ctrl_if.sv
// ID-stage / pipeline-control signal bundle; master is the ID side, slave the control block.
interface riscv_pipe_ctrl_if #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int NUM_RD_PORTS  = 2,
    parameter int FWD_STAGES    = 3,
    parameter int CNT_WIDTH     = 32
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic                                   id_valid;
    logic [NUM_RD_PORTS*RF_ADDR_WIDTH-1:0]  id_rs_addr;
    logic [NUM_RD_PORTS-1:0]                id_rs_used;
    logic [RF_ADDR_WIDTH-1:0]               id_rd_addr;
    logic                                   id_reg_write;
    logic                                   id_mem_read;
    logic                                   ex_redirect;
    logic                                   mem_stall;
    logic                                   id_ready;
    logic                                   issue;
    logic                                   stall_if;
    logic                                   bubble_ex;
    logic                                   flush_id;
    logic [NUM_RD_PORTS*SEL_W-1:0]          fwd_sel;
    logic [CNT_WIDTH-1:0]                   stall_cnt;

    modport master (
        output id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_reg_write, id_mem_read,
               ex_redirect, mem_stall,
        input  id_ready, issue, stall_if, bubble_ex, flush_id, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_reg_write, id_mem_read,
               ex_redirect, mem_stall,
        output id_ready, issue, stall_if, bubble_ex, flush_id, fwd_sel, stall_cnt
    );

endinterface

// File: rtl/riscv_fwd_match.sv
// Youngest-match search of one source register against the in-flight table.
module riscv_fwd_match
    import riscv_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int FWD_STAGES    = 3,
    localparam int IDX_W        = (FWD_STAGES > 1) ? $clog2(FWD_STAGES) : 1
) (
    input  logic [RF_ADDR_WIDTH-1:0] rs,
    input  pipe_entry_t              tbl [FWD_STAGES],
    output logic                     hit,
    output logic [IDX_W-1:0]         idx,
    output logic                     is_ld
);

    logic match_s;

    // Scan oldest to youngest so the lowest matching index is what remains.
    always_comb begin
        hit     = 1'b0;
        idx     = {IDX_W{1'b0}};
        is_ld   = 1'b0;
        match_s = 1'b0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            match_s = (rs != {RF_ADDR_WIDTH{1'b0}}) && tbl[i].valid && tbl[i].wr &&
                      (tbl[i].rd == RF_ADDR_MAX'(rs));
            hit     = match_s ? 1'b1        : hit;
            idx     = match_s ? IDX_W'(i)   : idx;
            is_ld   = match_s ? tbl[i].ld   : is_ld;
        end
    end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control: in-flight write tracking, forwarding selects, load-use
// stalls, redirect squashing and memory-stall freeze.
module riscv_pipe_ctrl
    import riscv_pkg::*;
#(
    parameter int RF_ADDR_WIDTH    = 5,
    parameter int NUM_RD_PORTS     = 2,
    parameter int FWD_STAGES       = 3,
    parameter int LOAD_LAT         = 1,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_WIDTH        = 32
) (
    input  logic              clk,
    input  logic              sft_rst,
    riscv_pipe_ctrl_if.slave  ctl
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);
    localparam int IDX_W = (FWD_STAGES > 1) ? $clog2(FWD_STAGES) : 1;
    localparam int SQ_W  = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES + 1) : 1;

    pipe_entry_t              tbl_r [FWD_STAGES];
    ctrl_state_e              state_r, state_nx_s;
    logic [SQ_W-1:0]          sq_cnt_r, sq_cnt_nx_s;
    logic [CNT_WIDTH-1:0]     stall_cnt_r;
    logic [NUM_RD_PORTS-1:0]  hit_s, ld_s, luse_vec_s;
    logic [IDX_W-1:0]         idx_s [NUM_RD_PORTS];
    logic [NUM_RD_PORTS*SEL_W-1:0] fwd_sel_s;
    logic                     luse_s, issue_s, ready_s, stall_if_s, bubble_s, flush_s, cnt_inc_s;
    pipe_entry_t              new_entry_s;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        riscv_fwd_match #(
            .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
            .FWD_STAGES    (FWD_STAGES)
        ) u_match (
            .rs    (ctl.id_rs_addr[p*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]),
            .tbl   (tbl_r),
            .hit   (hit_s[p]),
            .idx   (idx_s[p]),
            .is_ld (ld_s[p])
        );
    end

    // Per-port forwarding select and load-use detection.
    always_comb begin
        fwd_sel_s  = {(NUM_RD_PORTS*SEL_W){1'b0}};
        luse_vec_s = {NUM_RD_PORTS{1'b0}};
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            fwd_sel_s[p*SEL_W +: SEL_W] = hit_s[p] ? (SEL_W'(idx_s[p]) + SEL_W'(1)) : SEL_W'(FWD_RF);
            luse_vec_s[p] = ctl.id_valid & ctl.id_rs_used[p] & hit_s[p] & ld_s[p] &
                            (int'(idx_s[p]) < LOAD_LAT);
        end
        luse_s = |luse_vec_s;
    end

    // Next state and handshake outputs; a frozen pipeline overrides everything.
    always_comb begin
        state_nx_s = state_r;
        sq_cnt_nx_s = sq_cnt_r;
        issue_s    = 1'b0;
        ready_s    = 1'b0;
        stall_if_s = 1'b0;
        bubble_s   = 1'b0;
        flush_s    = 1'b0;
        cnt_inc_s  = 1'b0;
        if (ctl.mem_stall) begin
            stall_if_s = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (ctl.ex_redirect) begin
                        flush_s  = 1'b1;
                        bubble_s = 1'b1;
                        if (REDIRECT_BUBBLES > 1) begin
                            state_nx_s  = SQUASH;
                            sq_cnt_nx_s = SQ_W'(REDIRECT_BUBBLES - 1);
                        end else begin
                            state_nx_s  = RUN;
                        end
                    end else if (luse_s) begin
                        stall_if_s = 1'b1;
                        bubble_s   = 1'b1;
                        cnt_inc_s  = 1'b1;
                    end else begin
                        ready_s = 1'b1;
                        issue_s = ctl.id_valid;
                    end
                end
                SQUASH: begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                    if (sq_cnt_r <= SQ_W'(1)) begin
                        state_nx_s  = RUN;
                        sq_cnt_nx_s = {SQ_W{1'b0}};
                    end else begin
                        sq_cnt_nx_s = sq_cnt_r - SQ_W'(1);
                    end
                end
                default: begin
                    state_nx_s  = RUN;
                    sq_cnt_nx_s = {SQ_W{1'b0}};
                end
            endcase
        end
        new_entry_s = issue_s ? make_entry(RF_ADDR_MAX'(ctl.id_rd_addr), ctl.id_reg_write,
                                           ctl.id_mem_read) : ENTRY_NONE;
    end

    // Table shift, FSM and stall counter; all hold while memory stalls.
    always_ff @(posedge clk) begin
        if (sft_rst) begin
            state_r     <= RUN;
            sq_cnt_r    <= {SQ_W{1'b0}};
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
            for (int i = 0; i < FWD_STAGES; i++) tbl_r[i] <= ENTRY_NONE;
        end else if (!ctl.mem_stall) begin
            state_r  <= state_nx_s;
            sq_cnt_r <= sq_cnt_nx_s;
            if (cnt_inc_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
            end
            tbl_r[0] <= new_entry_s;
            for (int i = 1; i < FWD_STAGES; i++) tbl_r[i] <= tbl_r[i-1];
        end
    end

    assign ctl.fwd_sel   = fwd_sel_s;
    assign ctl.issue     = issue_s;
    assign ctl.id_ready  = ready_s;
    assign ctl.stall_if  = stall_if_s;
    assign ctl.bubble_ex = bubble_s;
    assign ctl.flush_id  = flush_s;
    assign ctl.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl with REDIRECT_BUBBLES = 2; expectations
// are queued as stimulus is driven and popped when outputs are sampled.
module tb_riscv_pipe_ctrl;
    import riscv_pkg::*;

    localparam int RFW = 5;
    localparam int NRP = 2;
    localparam int FWS = 3;
    localparam int CNW = 32;

    logic clk = 1'b0;
    logic sft_rst;
    always #5 clk = ~clk;

    riscv_pipe_ctrl_if #(.RF_ADDR_WIDTH(RFW), .NUM_RD_PORTS(NRP), .FWD_STAGES(FWS),
                         .CNT_WIDTH(CNW)) bus ();

    riscv_pipe_ctrl #(
        .RF_ADDR_WIDTH(RFW), .NUM_RD_PORTS(NRP), .FWD_STAGES(FWS), .LOAD_LAT(1),
        .REDIRECT_BUBBLES(2), .CNT_WIDTH(CNW)
    ) dut (
        .clk     (clk),
        .sft_rst (sft_rst),
        .ctl     (bus)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_v(input logic [63:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic redir, input logic mst);
        bus.id_valid     = v;
        bus.id_rs_addr   = {rs1, rs0};
        bus.id_rs_used   = used;
        bus.id_rd_addr   = rd;
        bus.id_reg_write = wr;
        bus.id_mem_read  = ld;
        bus.ex_redirect  = redir;
        bus.mem_stall    = mst;
    endtask

    task automatic exp_ctl(input string step, input logic [3:0] fwd, input logic iss,
                           input logic rdy, input logic sif, input logic bub, input logic fl);
        push_exp({step, ".fwd_sel"},   64'(fwd));
        push_exp({step, ".issue"},     64'(iss));
        push_exp({step, ".id_ready"},  64'(rdy));
        push_exp({step, ".stall_if"},  64'(sif));
        push_exp({step, ".bubble_ex"}, 64'(bub));
        push_exp({step, ".flush_id"},  64'(fl));
    endtask

    task automatic chk_ctl();
        #1;
        check_v(64'(bus.fwd_sel));
        check_v(64'(bus.issue));
        check_v(64'(bus.id_ready));
        check_v(64'(bus.stall_if));
        check_v(64'(bus.bubble_ex));
        check_v(64'(bus.flush_id));
    endtask

    task automatic chk_cnt(input string step, input logic [31:0] v);
        push_exp({step, ".stall_cnt"}, 64'(v));
        check_v(64'(bus.stall_cnt));
    endtask

    initial begin
        // Reset
        sft_rst = 1'b1;
        drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        exp_ctl("rst", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl();
        chk_cnt("rst", 32'd0);
        drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_ctl("rst_mst", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); chk_ctl();
        sft_rst = 1'b0;
        drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Back-to-back ALU forwarding from x5 through EX, MEM, WB then RF
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("alu_issue", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("alu_fwd1", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        exp_ctl("alu_fwd2", 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        exp_ctl("alu_fwd3", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        exp_ctl("alu_fwd0", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();

        // Load-use on port 1
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_ctl("ld_issue", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("luse_stall", 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); chk_ctl(); cyc();
        exp_ctl("luse_go", 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl();
        chk_cnt("luse", 32'd1); cyc();
        drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_ctl("drain", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        end

        // Youngest wins for x3; x0 never forwards
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("yw_a", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("yw_b", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("yw_c", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("youngest", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b0, 5'd3, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("x0_src", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();

        // Memory stall for 3 cycles with a redirect that must be ignored
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'd3, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, (i == 1), 1'b1);
            exp_ctl("frozen", 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); chk_ctl(); cyc();
        end
        drv(1'b1, 5'd3, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("resume", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b0, 5'd12, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("resume2", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl();
        chk_cnt("frozen", 32'd1); cyc();

        // Redirect squashes ID for two cycles
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_ctl("redir1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk_ctl(); cyc();
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("redir2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk_ctl(); cyc();
        exp_ctl("redir_end", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();

        // Redirect coincident with load-use: flush wins, no stall counted
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_ctl("ld8", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_ctl("redir_luse", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk_ctl(); cyc();
        drv(1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("redir_luse2", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk_ctl();
        chk_cnt("redir_luse", 32'd1); cyc();
        drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("redir_luse3", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();

        // Soft reset while entries are valid and the FSM is squashing
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("fill10", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("fill11", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_ctl("fill13", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();
        drv(1'b0, 5'd13, 5'd11, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_ctl("full_redir", 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk_ctl(); cyc();
        drv(1'b0, 5'd13, 5'd11, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        sft_rst = 1'b1;
        exp_ctl("pre_srst", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk_ctl();
        chk_cnt("pre_srst", 32'd1); cyc();
        sft_rst = 1'b0;
        exp_ctl("post_srst", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl();
        chk_cnt("post_srst", 32'd0); cyc();
        drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ctl("post_srst_run", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); chk_ctl(); cyc();

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_pipe_ctrl.md
Name: riscv_pipe_ctrl

Overview:
- Parametrised pipeline control block for the in-order RV64I core.
- Sits between ID and the later stages. It tracks in-flight register writes and produces per-port forwarding selects.
- Raises load-use stalls, squashes the ID instruction on a taken branch or jump, and freezes the pipeline on a memory stall.
- Replaces the fixed, hazard-free stage chaining with a general N-stage, M-read-port control.

Parameters:
- RF_ADDR_WIDTH, 5: register file address width.
- NUM_RD_PORTS, 2: source operands checked per ID instruction.
- FWD_STAGES, 3: tracked stages after ID (entry 0 = EX … entry FWD_STAGES-1 = WB).
- LOAD_LAT, 1: a load result is forwardable only from entry index >= LOAD_LAT.
- REDIRECT_BUBBLES, 1: cycles ID is squashed after a redirect (>=1).
- CNT_WIDTH, 32: stall performance counter width.

Ports:
- clk  in  1  clock
- sft_rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds an instruction
- id_rs_addr  in  NUM_RD_PORTS*RF_ADDR_WIDTH  source register addresses, port p at [p*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]
- id_rs_used  in  NUM_RD_PORTS  per-port source-used flag
- id_rd_addr  in  RF_ADDR_WIDTH  destination register
- id_reg_write  in  1  ID instruction writes the RF
- id_mem_read  in  1  ID instruction is a load
- ex_redirect  in  1  taken branch/jump resolved in EX (1-cycle pulse)
- mem_stall  in  1  data memory not ready; freeze request
- id_ready  out  1  ID may advance this cycle
- issue  out  1  ID instruction enters EX this cycle
- stall_if  out  1  hold PC and the IF/ID register
- bubble_ex  out  1  load a bubble into ID/EX
- flush_id  out  1  kill the instruction in IF/ID
- fwd_sel  out  NUM_RD_PORTS*SEL_W  per port: 0 = RF, k = entry k-1; SEL_W = $clog2(FWD_STAGES+1)
- stall_cnt  out  CNT_WIDTH  saturating count of load-use stall cycles

Behaviour:
- The clock is clk. The reset is sft_rst: synchronous, active-high. There is no other reset.
- Reset state:
  - all entries invalid; FSM = RUN; squash counter = 0; stall_cnt = 0.
  - resulting outputs: fwd_sel = 0, flush_id = 0, bubble_ex = 0.
  - id_ready = ~mem_stall.
  - Reset mid-operation discards every tracked entry, and the FSM returns to RUN.
- In-flight table: FWD_STAGES entries, each {valid, rd, wr, ld}. An entry with rd == 0 is stored with wr = 0.
- Advance (when ~mem_stall):
  - entry[i+1] <= entry[i];
  - entry[0] <= {1, id_rd_addr, id_reg_write, id_mem_read} if issue, else invalid.
  - The oldest entry drops off the end.
- Freeze: when mem_stall = 1, the table, FSM, squash counter and stall_cnt all hold, ex_redirect is ignored (EX holds it), id_ready = 0, stall_if = 1, and bubble_ex = flush_id = 0.
- Forwarding, combinational, per port p:
  - Find the youngest (lowest i) entry with valid & wr & rd == rs[p]; fwd_sel[p] = i+1.
  - fwd_sel[p] = 0 if there is no match or rs[p] == 0.
- Load-use: luse = OR over p of (id_valid & rs_used[p] & youngest match is ld & i < LOAD_LAT). Older non-youngest matches are ignored.
- FSM:
  - RUN:
    - ex_redirect → flush_id = 1, bubble_ex = 1, issue = 0.
    - If REDIRECT_BUBBLES > 1, go to SQUASH with counter = REDIRECT_BUBBLES-1.
  - SQUASH: flush_id = 1, bubble_ex = 1, issue = 0. Decrement the counter; at 1 go to RUN.
- Priority in RUN without mem_stall: redirect > luse > normal.
  - luse: stall_if = 1, bubble_ex = 1, id_ready = 0. stall_cnt += 1, saturating at all-ones.
  - normal: id_ready = 1, issue = id_valid.
- A redirect arriving while luse is active wins. The stall is dropped and not counted.
- Latency:
  - forwarding and stall decisions are same-cycle combinational from ID inputs and table state;
  - table updates take effect the next cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - the in-flight entry typedef pipe_entry_t {valid, rd, wr, ld};
  - the FSM enum {RUN, SQUASH};
  - the fwd_sel encoding constant FWD_RF = 0.
- One natural sub-module: riscv_fwd_match. It takes a single port and the table, and returns the youngest-match index and the is-load flag. It is instantiated NUM_RD_PORTS times.

Test Plan:
- Back-to-back ALU: issue addi x5; next cycle ID reads rs1 = x5 → fwd_sel[0] = 1. Following cycle → 2. Then 3. Then 0.
- Load-use: issue ld x7; next ID uses x7 on port 1 → stall_if = 1, bubble_ex = 1 for exactly 1 cycle, then issue = 1 with fwd_sel[1] = 2; stall_cnt = 1.
- Youngest wins: x3 written at entries 0 and 2 → fwd_sel = 1. x0 as source with a matching rd = 0 write → fwd_sel = 0.
- Redirect with REDIRECT_BUBBLES = 2: ex_redirect pulse → flush_id = 1 for 2 cycles, and no issue. Redirect coincident with load-use → flush wins and stall_cnt is unchanged.
- mem_stall held 3 cycles mid-stream → table and fwd_sel frozen, id_ready = 0 throughout, and the sequence resumes identically afterwards.
- sft_rst asserted with 3 valid entries and in SQUASH → next cycle all fwd_sel = 0, FSM RUN, stall_cnt = 0.
